// File: rtl/dcache_pkg.sv
// Shared definitions for the uncached data-side bridge.
//   - SZ_BYTE / SZ_HALF / SZ_WORD : access size encodings (3 behaves as word)
//   - load_state_e                : load FSM states
//   - wbuf_entry_t                : one buffered store {addr, data, size, wstrb}
package dcache_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_RREQ  = 3'd2,
        ST_RWAIT = 3'd3,
        ST_RESP  = 3'd4
    } load_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [3:0]  wstrb;
    } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Circular write buffer holding retired uncached stores until the bus takes them.
// Ports:
//   clk, rstn          : clock, asynchronous active-low reset
//   push_i/push_entry_i: enqueue one entry at the clock edge (caller guarantees !full_o)
//   pop_i              : drop the head entry at the clock edge (caller guarantees !empty_o)
//   head_o             : oldest entry, valid while !empty_o
//   count_o            : registered occupancy
//   full_o, empty_o    : decoded from count_o
module wbuf_fifo
    import dcache_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push_i,
    input  wbuf_entry_t            push_entry_i,
    input  logic                   pop_i,
    output wbuf_entry_t            head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int PW = $clog2(DEPTH);

    wbuf_entry_t   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: contents are meaningless once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/dcache_uncache_wbuf.sv
// Uncached data-access bridge: pipeline load/store port <-> memory bus.
// Stores retire into wbuf_fifo and drain in order; loads wait for the buffer
// to empty, issue a single read, and return extended byte/half/word data.
// Ports:
//   clk, rstn                       : clock, asynchronous active-low reset
//   *_pipeline_dcache / pipeline_*  : request from the pipeline
//   dcache_pipeline_ready/stall     : completion (stall = ~ready)
//   dout_dcache_pipeline            : registered extended load data
//   *_dcache_mem / dcache_mem_*     : bus request side; mem_dcache_* : bus responses
//   wbuf_empty, wbuf_count          : buffer status for fence logic
//   dbg_load_state                  : current load FSM state
//
// Handshake: the pipeline holds valid and all request fields stable until a
// cycle with ready = 1; that cycle completes the request. On the bus, req and
// its fields stay stable until addrOK; a write is done at addrOK, a read
// completes on a later dataOK. Only one bus request is outstanding.
module dcache_uncache_wbuf
    import dcache_pkg::*;
#(
    parameter int wbuf_depth   = 4,
    parameter int offset_width = 2
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [31:0]                       addr_pipeline_dcache,
    input  logic [31:0]                       din_pipeline_dcache,
    input  logic                              type_pipeline_dcache,
    input  logic [1:0]                        pipeline_dcache_size,
    input  logic [3:0]                        pipeline_dcache_wstrb,
    input  logic                              pipeline_dcache_sext,
    input  logic                              pipeline_dcache_valid,
    output logic                              dcache_pipeline_ready,
    output logic                              dcache_pipeline_stall,
    output logic [31:0]                       dout_dcache_pipeline,
    output logic [31:0]                       addr_dcache_mem,
    output logic [31:0]                       dout_dcache_mem,
    input  logic [32*(2<<offset_width)-1:0]   din_mem_dcache,
    output logic                              dcache_mem_req,
    output logic                              dcache_mem_wr,
    output logic [1:0]                        dcache_mem_size,
    output logic [3:0]                        dcache_mem_wstrb,
    input  logic                              mem_dcache_addrOK,
    input  logic                              mem_dcache_dataOK,
    output logic                              wbuf_empty,
    output logic [$clog2(wbuf_depth):0]       wbuf_count,
    output logic [2:0]                        dbg_load_state
);
    localparam int RW = 32*(2<<offset_width);

    load_state_e state_q, state_d;
    logic [31:0] ld_addr_q, ld_addr_d;
    logic [1:0]  ld_size_q, ld_size_d;
    logic        ld_sext_q, ld_sext_d;
    logic [31:0] dout_q, dout_d;

    logic        store_acc, drain_act, wb_pop, wb_full, wb_empty;
    wbuf_entry_t push_entry, head_entry;
    logic [$clog2(wbuf_depth):0] wb_count;
    logic [31:0] raw_word, ext_word;

    // Only the low word of the wide read bus carries data.
    logic unused_rdata;
    assign unused_rdata = ^din_mem_dcache[RW-1:32];

    // Full test uses the registered count: no same-cycle pop bypass.
    assign store_acc = pipeline_dcache_valid & type_pipeline_dcache &
                       (state_q == ST_IDLE) & ~wb_full;
    // Drain runs in the background while idle and while a load waits on it.
    assign drain_act = ~wb_empty & ((state_q == ST_IDLE) | (state_q == ST_DRAIN));
    assign wb_pop    = drain_act & mem_dcache_addrOK;

    assign push_entry = '{addr:  addr_pipeline_dcache,
                          data:  din_pipeline_dcache,
                          size:  pipeline_dcache_size,
                          wstrb: pipeline_dcache_wstrb};

    wbuf_fifo #(.DEPTH(wbuf_depth)) u_wbuf (
        .clk          (clk),
        .rstn         (rstn),
        .push_i       (store_acc),
        .push_entry_i (push_entry),
        .pop_i        (wb_pop),
        .head_o       (head_entry),
        .count_o      (wb_count),
        .full_o       (wb_full),
        .empty_o      (wb_empty)
    );

    // Lane extraction: shift the addressed byte down to bit 0, then extend.
    always_comb begin
        raw_word = din_mem_dcache[31:0] >> {ld_addr_q[1:0], 3'b000};
        case (ld_size_q)
            SZ_BYTE: ext_word = {{24{ld_sext_q & raw_word[7]}},  raw_word[7:0]};
            SZ_HALF: ext_word = {{16{ld_sext_q & raw_word[15]}}, raw_word[15:0]};
            default: ext_word = raw_word;
        endcase
    end

    always_comb begin
        state_d               = state_q;
        ld_addr_d             = ld_addr_q;
        ld_size_d             = ld_size_q;
        ld_sext_d             = ld_sext_q;
        dout_d                = dout_q;
        dcache_pipeline_ready = store_acc;
        dcache_mem_req        = 1'b0;
        dcache_mem_wr         = 1'b0;
        addr_dcache_mem       = '0;
        dout_dcache_mem       = '0;
        dcache_mem_size       = SZ_BYTE;
        dcache_mem_wstrb      = '0;

        if (drain_act) begin
            dcache_mem_req   = 1'b1;
            dcache_mem_wr    = 1'b1;
            addr_dcache_mem  = head_entry.addr;
            dout_dcache_mem  = head_entry.data;
            dcache_mem_size  = head_entry.size;
            dcache_mem_wstrb = head_entry.wstrb;
        end

        case (state_q)
            ST_IDLE: begin
                if (pipeline_dcache_valid && !type_pipeline_dcache) begin
                    ld_addr_d = addr_pipeline_dcache;
                    ld_size_d = pipeline_dcache_size;
                    ld_sext_d = pipeline_dcache_sext;
                    state_d   = wb_empty ? ST_RREQ : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wb_empty) state_d = ST_RREQ;
            end
            ST_RREQ: begin
                dcache_mem_req  = 1'b1;
                addr_dcache_mem = ld_addr_q;
                dcache_mem_size = ld_size_q;
                if (mem_dcache_addrOK) state_d = ST_RWAIT;
            end
            ST_RWAIT: begin
                if (mem_dcache_dataOK) begin
                    dout_d  = ext_word;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                dcache_pipeline_ready = 1'b1;
                state_d               = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            ld_addr_q <= '0;
            ld_size_q <= SZ_BYTE;
            ld_sext_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            ld_addr_q <= ld_addr_d;
            ld_size_q <= ld_size_d;
            ld_sext_q <= ld_sext_d;
            dout_q    <= dout_d;
        end
    end

    assign dcache_pipeline_stall = ~dcache_pipeline_ready;
    assign dout_dcache_pipeline  = dout_q;
    assign wbuf_empty            = wb_empty;
    assign wbuf_count            = wb_count;
    assign dbg_load_state        = state_q;

endmodule

// File: tb/tb_dcache_uncache_wbuf.sv
module tb_dcache_uncache_wbuf;
    import dcache_pkg::*;

    localparam int DEPTH = 4;
    localparam int OFFW  = 2;
    localparam int RW    = 32*(2<<OFFW);
    localparam int CW    = $clog2(DEPTH)+1;
    localparam int BW    = 71;  // {wr, addr, data, size, wstrb}

    logic          clk = 1'b0;
    logic          rstn;
    logic [31:0]   addr_pipeline_dcache;
    logic [31:0]   din_pipeline_dcache;
    logic          type_pipeline_dcache;
    logic [1:0]    pipeline_dcache_size;
    logic [3:0]    pipeline_dcache_wstrb;
    logic          pipeline_dcache_sext;
    logic          pipeline_dcache_valid;
    logic          dcache_pipeline_ready;
    logic          dcache_pipeline_stall;
    logic [31:0]   dout_dcache_pipeline;
    logic [31:0]   addr_dcache_mem;
    logic [31:0]   dout_dcache_mem;
    logic [RW-1:0] din_mem_dcache = '0;
    logic          dcache_mem_req;
    logic          dcache_mem_wr;
    logic [1:0]    dcache_mem_size;
    logic [3:0]    dcache_mem_wstrb;
    logic          mem_dcache_addrOK = 1'b0;
    logic          mem_dcache_dataOK = 1'b0;
    logic          wbuf_empty;
    logic [CW-1:0] wbuf_count;
    logic [2:0]    dbg_load_state;

    int checks   = 0;
    int failures = 0;

    logic [BW-1:0] exp_q[$];     // expected bus transactions in issue order
    logic [31:0]   exp_ld_q[$];  // expected load results

    // bus model controls
    logic        bus_block = 1'b0;
    int          data_lat  = 1;
    int          rd_cnt    = 0;
    logic [31:0] rd_word   = '0;

    dcache_uncache_wbuf #(.wbuf_depth(DEPTH), .offset_width(OFFW)) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .addr_pipeline_dcache  (addr_pipeline_dcache),
        .din_pipeline_dcache   (din_pipeline_dcache),
        .type_pipeline_dcache  (type_pipeline_dcache),
        .pipeline_dcache_size  (pipeline_dcache_size),
        .pipeline_dcache_wstrb (pipeline_dcache_wstrb),
        .pipeline_dcache_sext  (pipeline_dcache_sext),
        .pipeline_dcache_valid (pipeline_dcache_valid),
        .dcache_pipeline_ready (dcache_pipeline_ready),
        .dcache_pipeline_stall (dcache_pipeline_stall),
        .dout_dcache_pipeline  (dout_dcache_pipeline),
        .addr_dcache_mem       (addr_dcache_mem),
        .dout_dcache_mem       (dout_dcache_mem),
        .din_mem_dcache        (din_mem_dcache),
        .dcache_mem_req        (dcache_mem_req),
        .dcache_mem_wr         (dcache_mem_wr),
        .dcache_mem_size       (dcache_mem_size),
        .dcache_mem_wstrb      (dcache_mem_wstrb),
        .mem_dcache_addrOK     (mem_dcache_addrOK),
        .mem_dcache_dataOK     (mem_dcache_dataOK),
        .wbuf_empty            (wbuf_empty),
        .wbuf_count            (wbuf_count),
        .dbg_load_state        (dbg_load_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- bus responder ----------------
    // addrOK follows req unless blocked; read data returns data_lat cycles later.
    always begin
        @(posedge clk);
        #2;
        if (!rstn) begin
            rd_cnt            = 0;
            mem_dcache_addrOK = 1'b0;
            mem_dcache_dataOK = 1'b0;
        end else begin
            mem_dcache_dataOK = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt = rd_cnt - 1;
                if (rd_cnt == 0) mem_dcache_dataOK = 1'b1;
            end
            mem_dcache_addrOK = dcache_mem_req & ~bus_block;
            if (mem_dcache_addrOK && !dcache_mem_wr) rd_cnt = data_lat;
        end
        din_mem_dcache = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                          (mem_dcache_dataOK ? rd_word : ~rd_word)};
    end

    // ---------------- scoreboard: bus side ----------------
    always @(negedge clk) begin : bus_mon
        logic [BW-1:0] got;
        logic [BW-1:0] e;
        if (rstn && dcache_mem_req && mem_dcache_addrOK) begin
            got = {dcache_mem_wr, addr_dcache_mem, (dcache_mem_wr ? dout_dcache_mem : 32'h0),
                   dcache_mem_size, dcache_mem_wstrb};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL bus_unexpected got=%h exp=<none>", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL bus_txn got=%h exp=%h", got, e);
                end
            end
            if (!dcache_mem_wr) begin
                checks++;
                if (wbuf_empty !== 1'b1) begin
                    failures++;
                    $display("FAIL read_before_drain wbuf_empty got=%b exp=1", wbuf_empty);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] sz, input logic sx);
        logic [7:0] b [5];
        logic [7:0] lo, hi;
        int o;
        o = int'(off);
        b[0] = w[7:0]; b[1] = w[15:8]; b[2] = w[23:16]; b[3] = w[31:24]; b[4] = 8'h00;
        lo = b[o];
        hi = b[o+1];
        if (sz == SZ_BYTE) return (sx && lo[7]) ? {24'hFFFFFF, lo} : {24'h000000, lo};
        if (sz == SZ_HALF) return (sx && hi[7]) ? {16'hFFFF, hi, lo} : {16'h0000, hi, lo};
        return {b[3], b[2], b[1], b[0]};
    endfunction

    // ---------------- drivers ----------------
    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] sz, input logic [3:0] st);
        int n;
        n = 0;
        exp_q.push_back({1'b1, a, d, sz, st});
        pipeline_dcache_valid = 1'b1;
        type_pipeline_dcache  = 1'b1;
        addr_pipeline_dcache  = a;
        din_pipeline_dcache   = d;
        pipeline_dcache_size  = sz;
        pipeline_dcache_wstrb = st;
        pipeline_dcache_sext  = 1'b0;
        @(negedge clk);
        while (dcache_pipeline_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dcache_pipeline_ready !== 1'b1) begin
            failures++;
            $display("FAIL store_timeout addr=%h ready got=%b exp=1", a, dcache_pipeline_ready);
        end
        @(posedge clk);
        #1;
        pipeline_dcache_valid = 1'b0;
    endtask

    task automatic start_load(input logic [31:0] a, input logic [1:0] sz,
                              input logic sx, input logic [31:0] expv);
        exp_ld_q.push_back(expv);
        exp_q.push_back({1'b0, a, 32'h0, sz, 4'h0});
        pipeline_dcache_valid = 1'b1;
        type_pipeline_dcache  = 1'b0;
        addr_pipeline_dcache  = a;
        din_pipeline_dcache   = 32'h0;
        pipeline_dcache_size  = sz;
        pipeline_dcache_wstrb = 4'h0;
        pipeline_dcache_sext  = sx;
    endtask

    task automatic finish_load();
        int n;
        logic [31:0] e;
        n = 0;
        while (dcache_pipeline_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        e = exp_ld_q.pop_front();
        checks++;
        if (dcache_pipeline_ready !== 1'b1 || dout_dcache_pipeline !== e) begin
            failures++;
            $display("FAIL load_data addr=%h ready=%b got=%h exp=%h", addr_pipeline_dcache,
                     dcache_pipeline_ready, dout_dcache_pipeline, e);
        end
        @(posedge clk);
        #1;
        pipeline_dcache_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        @(negedge clk);
        while (!(wbuf_empty === 1'b1 && dcache_mem_req === 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (wbuf_empty !== 1'b1) begin
            failures++;
            $display("FAIL drain_timeout wbuf_count got=%0d exp=0", wbuf_count);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (dcache_pipeline_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", dcache_pipeline_ready); end
        checks++; if (dcache_pipeline_stall !== 1'b1) begin failures++; $display("FAIL reset_stall got=%b exp=1", dcache_pipeline_stall); end
        checks++; if (dcache_mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", dcache_mem_req); end
        checks++; if (dout_dcache_pipeline !== 32'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout_dcache_pipeline); end
        checks++; if (wbuf_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", wbuf_empty); end
        checks++; if (wbuf_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", wbuf_count); end
        checks++; if (dbg_load_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_load_state); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_burst();
        int n;
        bus_block = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b1, 32'h1000 + 32'(i*4), 32'hA0A0_0000 + 32'(i), SZ_WORD, 4'hF});
            pipeline_dcache_valid = 1'b1;
            type_pipeline_dcache  = 1'b1;
            addr_pipeline_dcache  = 32'h1000 + 32'(i*4);
            din_pipeline_dcache   = 32'hA0A0_0000 + 32'(i);
            pipeline_dcache_size  = SZ_WORD;
            pipeline_dcache_wstrb = 4'hF;
            @(negedge clk);
            checks++;
            if (dcache_pipeline_ready !== 1'b1) begin
                failures++;
                $display("FAIL burst_ready idx=%0d got=%b exp=1", i, dcache_pipeline_ready);
            end
            @(posedge clk);
            #1;
        end
        // fifth store against a full buffer
        exp_q.push_back({1'b1, 32'h1010, 32'hA0A0_0004, SZ_BYTE, 4'h1});
        addr_pipeline_dcache  = 32'h1010;
        din_pipeline_dcache   = 32'hA0A0_0004;
        pipeline_dcache_size  = SZ_BYTE;
        pipeline_dcache_wstrb = 4'h1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (dcache_pipeline_ready !== 1'b0) begin
                failures++;
                $display("FAIL full_ready cyc=%0d got=%b exp=0", k, dcache_pipeline_ready);
            end
        end
        checks++;
        if (wbuf_count !== CW'(4)) begin
            failures++;
            $display("FAIL full_count got=%0d exp=4", wbuf_count);
        end
        @(posedge clk);
        #1;
        bus_block = 1'b0;
        n = 0;
        @(negedge clk);
        while (dcache_pipeline_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 1 || wbuf_count !== CW'(3)) begin
            failures++;
            $display("FAIL fifth_accept wait got=%0d count=%0d exp wait=1 count=3", n, wbuf_count);
        end
        @(posedge clk);
        #1;
        pipeline_dcache_valid = 1'b0;
        wait_empty();
    endtask

    task automatic test_push_pop();
        bus_block = 1'b1;
        do_store(32'h2000, 32'hDEAD_0001, SZ_WORD, 4'hF);
        bus_block = 1'b0;
        exp_q.push_back({1'b1, 32'h2004, 32'hDEAD_0002, SZ_HALF, 4'h3});
        pipeline_dcache_valid = 1'b1;
        type_pipeline_dcache  = 1'b1;
        addr_pipeline_dcache  = 32'h2004;
        din_pipeline_dcache   = 32'hDEAD_0002;
        pipeline_dcache_size  = SZ_HALF;
        pipeline_dcache_wstrb = 4'h3;
        @(negedge clk);
        checks++;
        if (dcache_pipeline_ready !== 1'b1 || mem_dcache_addrOK !== 1'b1 || wbuf_count !== CW'(1)) begin
            failures++;
            $display("FAIL pushpop_same_cycle ready=%b addrOK=%b count=%0d exp 1 1 1",
                     dcache_pipeline_ready, mem_dcache_addrOK, wbuf_count);
        end
        @(posedge clk);
        #1;
        pipeline_dcache_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wbuf_count !== CW'(1)) begin
            failures++;
            $display("FAIL pushpop_count got=%0d exp=1", wbuf_count);
        end
        wait_empty();
    endtask

    task automatic test_load_order();
        rd_word   = 32'h1122_3344;
        bus_block = 1'b1;
        do_store(32'h100, 32'h1122_3344, SZ_WORD, 4'hF);
        start_load(32'h100, SZ_WORD, 1'b0, 32'h1122_3344);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (dcache_mem_req !== 1'b1 || dcache_mem_wr !== 1'b1) begin
                failures++;
                $display("FAIL order_hold cyc=%0d req=%b wr=%b exp 1 1", k, dcache_mem_req, dcache_mem_wr);
            end
        end
        checks++;
        if (dbg_load_state !== ST_DRAIN) begin
            failures++;
            $display("FAIL order_state got=%0d exp=%0d", dbg_load_state, ST_DRAIN);
        end
        @(posedge clk);
        #1;
        bus_block = 1'b0;
        finish_load();
    endtask

    task automatic test_extract();
        logic [31:0] t_addr [7];
        logic [1:0]  t_size [7];
        logic        t_sext [7];
        logic [31:0] t_exp  [7];
        logic [31:0] a;
        logic [1:0]  off, sz;
        logic        sx;
        t_addr = '{32'h203, 32'h203, 32'h202, 32'h201, 32'h200, 32'h200, 32'h200};
        t_size = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_WORD, 2'd3, SZ_BYTE};
        t_sext = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        t_exp  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_FF7F,
                   32'h80FF_7F01, 32'h80FF_7F01, 32'h0000_0001};
        rd_word = 32'h80FF_7F01;
        for (int i = 0; i < 7; i++) begin
            start_load(t_addr[i], t_size[i], t_sext[i], t_exp[i]);
            finish_load();
        end
        for (int i = 0; i < 6; i++) begin
            rd_word = $urandom();
            sz  = 2'($urandom_range(0, 3));
            off = (sz >= SZ_WORD) ? 2'd0 : 2'($urandom_range(0, 3));
            sx  = 1'($urandom_range(0, 1));
            a   = 32'h3000 | {30'h0, off};
            start_load(a, sz, sx, ref_load(rd_word, off, sz, sx));
            finish_load();
        end
    endtask

    task automatic test_min_latency();
        int lat;
        rd_word  = 32'hCAFE_9234;
        data_lat = 1;
        start_load(32'h304, SZ_HALF, 1'b1, 32'hFFFF_9234);
        lat = 0;
        @(negedge clk);
        while (dcache_pipeline_ready !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                checks++;
                if (dcache_mem_req !== 1'b1 || dcache_mem_wr !== 1'b0 || dcache_mem_wstrb !== 4'h0 || dcache_mem_size !== SZ_HALF) begin
                    failures++;
                    $display("FAIL rreq_fields req=%b wr=%b wstrb=%h size=%0d exp 1 0 0 1",
                             dcache_mem_req, dcache_mem_wr, dcache_mem_wstrb, dcache_mem_size);
                end
            end
        end
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL load_latency got=%0d exp=3", lat);
        end
        finish_load();
    endtask

    task automatic test_reset_mid_read();
        int n;
        data_lat = 4;
        rd_word  = 32'h55AA_55AA;
        exp_q.push_back({1'b0, 32'h400, 32'h0, SZ_WORD, 4'h0});
        pipeline_dcache_valid = 1'b1;
        type_pipeline_dcache  = 1'b0;
        addr_pipeline_dcache  = 32'h400;
        pipeline_dcache_size  = SZ_WORD;
        pipeline_dcache_sext  = 1'b0;
        n = 0;
        @(negedge clk);
        while (dbg_load_state !== ST_RWAIT && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dbg_load_state !== ST_RWAIT) begin
            failures++;
            $display("FAIL reach_rwait state got=%0d exp=%0d", dbg_load_state, ST_RWAIT);
        end
        #1;
        rstn = 1'b0;
        pipeline_dcache_valid = 1'b0;
        #1;
        checks++;
        if (dcache_mem_req !== 1'b0 || dcache_pipeline_ready !== 1'b0 || dcache_pipeline_stall !== 1'b1) begin
            failures++;
            $display("FAIL midread_reset req=%b ready=%b stall=%b exp 0 0 1",
                     dcache_mem_req, dcache_pipeline_ready, dcache_pipeline_stall);
        end
        checks++;
        if (wbuf_count !== '0 || dbg_load_state !== ST_IDLE || dout_dcache_pipeline !== 32'h0) begin
            failures++;
            $display("FAIL midread_state count=%0d state=%0d dout=%h exp 0 0 0",
                     wbuf_count, dbg_load_state, dout_dcache_pipeline);
        end
        exp_ld_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn     = 1'b1;
        data_lat = 1;

        // reset with stores still buffered discards them
        bus_block = 1'b1;
        do_store(32'h500, 32'h0000_0011, SZ_WORD, 4'hF);
        do_store(32'h504, 32'h0000_0022, SZ_WORD, 4'hF);
        @(negedge clk);
        checks++;
        if (wbuf_count !== CW'(2)) begin
            failures++;
            $display("FAIL prereset_count got=%0d exp=2", wbuf_count);
        end
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if (wbuf_count !== '0 || wbuf_empty !== 1'b1 || dcache_mem_req !== 1'b0) begin
            failures++;
            $display("FAIL wbuf_reset count=%0d empty=%b req=%b exp 0 1 0", wbuf_count, wbuf_empty, dcache_mem_req);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn      = 1'b1;
        bus_block = 1'b0;

        rd_word = 32'h0BAD_F00D;
        start_load(32'h404, SZ_WORD, 1'b0, 32'h0BAD_F00D);
        finish_load();
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        rstn                  = 1'b0;
        addr_pipeline_dcache  = '0;
        din_pipeline_dcache   = '0;
        type_pipeline_dcache  = 1'b0;
        pipeline_dcache_size  = SZ_BYTE;
        pipeline_dcache_wstrb = '0;
        pipeline_dcache_sext  = 1'b0;
        pipeline_dcache_valid = 1'b0;

        test_reset();
        test_store_burst();
        test_push_pop();
        test_load_order();
        test_extract();
        test_min_latency();
        test_reset_mid_read();

        repeat (5) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL bus_leftover got=%0d exp=0", exp_q.size());
        end
        checks++;
        if (exp_ld_q.size() != 0) begin
            failures++;
            $display("FAIL load_leftover got=%0d exp=0", exp_ld_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
